// File: rtl/prog_loader_pkg.sv
// Shared loader types: FSM state encoding and image-header field constants.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        W_LO,
        W_HI,
        START,
        RUN,
        FIN
    } state_t;

    localparam logic [7:0] LEN_HI_MASK = 8'hF0;
    localparam int         WORD_HI_BIT = 0;

endpackage

// File: rtl/run_timer.sv
// Start-pulse length counter plus saturating RUN-cycle counter with timeout flag.
// Latency: o_start_last/o_timeout are combinational from the count; no backpressure.
module run_timer #(
    parameter int              SW      = 2,
    parameter int              CW      = 16,
    parameter logic [CW-1:0]   MAX_CYC = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start_en,
    input  logic          i_run_en,
    input  logic          i_done,
    output logic          o_start_last,
    output logic          o_timeout,
    output logic [CW-1:0] o_cycles
);

    localparam int SCW = (SW > 1) ? $clog2(SW) : 1;

    logic [SCW-1:0] r_scnt;
    logic [CW-1:0]  r_cyc;
    logic [CW-1:0]  w_cyc_nxt;
    logic           w_count;

    assign o_start_last = i_start_en && (r_scnt == SCW'(SW - 1));
    assign w_count      = i_run_en && !i_done;
    assign w_cyc_nxt    = (&r_cyc) ? r_cyc : r_cyc + 1'b1;
    // Timeout fires on the cycle whose count would reach the limit, so that count is kept.
    assign o_timeout    = w_count && (w_cyc_nxt >= MAX_CYC);
    assign o_cycles     = r_cyc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scnt <= '0;
        end else if (i_start_en) begin
            r_scnt <= o_start_last ? '0 : r_scnt + 1'b1;
        end else begin
            r_scnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= '0;
        end else if (i_start_en) begin
            r_cyc <= '0;
        end else if (w_count) begin
            r_cyc <= w_cyc_nxt;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte image into instruction memory, pulses Start, times the run.
// Latency: one byte per accepting edge, write strobe combinational in W_HI; in_ready low outside load states.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int            D       = 12,
    parameter int            SW      = 2,
    parameter int            CW      = 16,
    parameter logic [CW-1:0] MAX_CYC = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          im_we,
    output logic [D-1:0]  im_addr,
    output logic [8:0]    im_wdata,
    output logic          Start,
    input  logic          done,
    output logic          busy,
    output logic [CW-1:0] cycles,
    output logic          cycles_valid,
    output logic          err
);

    state_t        r_state;
    state_t        w_nxt;
    logic [11:0]   r_len;
    logic [7:0]    r_len_lo;
    logic [D-1:0]  r_idx;
    logic [7:0]    r_lo;
    logic          r_err;
    logic          r_cv;

    logic          w_ready;
    logic          w_acc;
    logic          w_im_we;
    logic [11:0]   w_len_full;
    logic          w_last_word;
    logic          w_start_last;
    logic          w_timeout;
    logic [CW-1:0] w_cycles;

    // Gated by rst_n so the port reads 0 while reset is held, even in IDLE.
    assign w_ready = rst_n && ((r_state == IDLE) || (r_state == LEN_HI) ||
                               (r_state == W_LO) || (r_state == W_HI));
    assign w_acc       = in_valid && w_ready;
    assign w_len_full  = {in_data[3:0], r_len_lo};
    assign w_last_word = (({1'b0, r_idx} + 1'b1) == (D + 1)'(r_len));

    run_timer #(
        .SW      (SW),
        .CW      (CW),
        .MAX_CYC (MAX_CYC)
    ) u_run_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start_en   (r_state == START),
        .i_run_en     (r_state == RUN),
        .i_done       (done),
        .o_start_last (w_start_last),
        .o_timeout    (w_timeout),
        .o_cycles     (w_cycles)
    );

    always_comb begin
        w_nxt   = r_state;
        w_im_we = 1'b0;
        case (r_state)
            IDLE:   if (w_acc) w_nxt = LEN_HI;
            LEN_HI: if (w_acc) w_nxt = (w_len_full == 12'd0) ? START : W_LO;
            W_LO:   if (w_acc) w_nxt = W_HI;
            W_HI: begin
                if (w_acc) begin
                    w_im_we = 1'b1;
                    w_nxt   = w_last_word ? START : W_LO;
                end
            end
            START:  if (w_start_last) w_nxt = RUN;
            RUN:    if (done || w_timeout) w_nxt = FIN;
            FIN:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len    <= '0;
            r_len_lo <= '0;
            r_idx    <= '0;
            r_lo     <= '0;
            r_err    <= 1'b0;
            r_cv     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_len_lo <= in_data;
                        r_idx    <= '0;
                        r_err    <= 1'b0;
                        r_cv     <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (w_acc) begin
                        r_len <= w_len_full;
                        if ((in_data & LEN_HI_MASK) != 8'd0) r_err <= 1'b1;
                    end
                end
                W_LO: if (w_acc) r_lo <= in_data;
                W_HI: if (w_acc) r_idx <= r_idx + 1'b1;
                RUN: begin
                    if (done) begin
                        r_cv <= 1'b1;
                    end else if (w_timeout) begin
                        r_cv  <= 1'b1;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = w_ready;
    assign im_we        = w_im_we;
    assign im_addr      = w_im_we ? r_idx : '0;
    assign im_wdata     = w_im_we ? {in_data[WORD_HI_BIT], r_lo} : 9'd0;
    assign Start        = (r_state == START);
    assign busy         = (r_state != IDLE) && (r_state != FIN);
    assign cycles       = w_cycles;
    assign cycles_valid = r_cv;
    assign err          = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench: stimulus pushes expected writes/results, a monitor pops and compares.
module tb_prog_loader;

    localparam int            D    = 12;
    localparam int            SW   = 2;
    localparam int            CW   = 16;
    localparam logic [15:0]   MAXC = 16'd20;

    logic          clk;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          im_we;
    logic [D-1:0]  im_addr;
    logic [8:0]    im_wdata;
    logic          Start;
    logic          done;
    logic          busy;
    logic [CW-1:0] cycles;
    logic          cycles_valid;
    logic          err;

    prog_loader #(.D(D), .SW(SW), .CW(CW), .MAX_CYC(MAXC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .Start        (Start),
        .done         (done),
        .busy         (busy),
        .cycles       (cycles),
        .cycles_valid (cycles_valid),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int cyc; int err; } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_d  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Core model: done rises on RUN cycle cur_d+1 and is held until the result appears.
    initial begin : done_drv
        int n;
        int phase;
        done  = 1'b0;
        n     = 0;
        phase = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done = 1'b0; phase = 0;
            end else if (Start) begin
                phase = 1; n = 0;
                done  = 1'($urandom_range(0, 1));
            end else if (phase != 0 && cycles_valid) begin
                done = 1'b0; phase = 0;
            end else if (phase == 1) begin
                n++;
                done = (n == cur_d + 1);
                if (done) phase = 2;
            end else if (phase == 0) begin
                done = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit   prev_cv;
        int   slen;
        wr_t  ew;
        res_t er;
        prev_cv = 1'b0;
        slen    = 0;
        forever begin
            @(negedge clk);
            #2;
            if (im_we) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h required=no write", im_addr, im_wdata);
                end else begin
                    ew = wr_q.pop_front();
                    check("wr_addr", 32'(im_addr), ew.addr);
                    check("wr_data", 32'(im_wdata), ew.data);
                end
            end
            if (!rst_n) slen = 0;
            else if (Start) slen++;
            else if (slen != 0) begin
                check("start_len", slen, SW);
                slen = 0;
            end
            if (cycles_valid && !prev_cv) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result cycles=%0d required=no result", cycles);
                end else begin
                    er = res_q.pop_front();
                    check("res_cycles", 32'(cycles), er.cyc);
                    check("res_err", 32'(err), er.err);
                    check("res_busy", 32'(busy), 0);
                end
            end
            prev_cv = cycles_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        bit sent;
        guard = 0;
        sent  = 1'b0;
        while (!sent && guard < 500) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready) begin
                    @(posedge clk);
                    sent = 1'b1;
                end
            end
        end
        if (!sent) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%0h accepted=0 required=1", b);
        end
    endtask

    task automatic run_prog(input int ws[$], input logic [3:0] junk, input int d, input bit noisy);
        int         len;
        int         w;
        logic [7:0] hi;
        wr_t        e;
        res_t       r;
        bit         rdy_seen;
        int         g;
        len   = ws.size();
        cur_d = d;
        for (int i = 0; i < len; i++) begin
            e.addr = i;
            e.data = ws[i];
            wr_q.push_back(e);
        end
        r.cyc = (d < int'(MAXC)) ? d : int'(MAXC);
        r.err = ((junk != 4'd0) || (d >= int'(MAXC))) ? 1 : 0;
        res_q.push_back(r);

        send_byte(len[7:0]);
        #1;
        check("hdr_clears_valid", 32'(cycles_valid), 0);
        check("hdr_clears_err", 32'(err), 0);
        send_byte({junk, len[11:8]});
        for (int i = 0; i < len; i++) begin
            w  = ws[i];
            hi = noisy ? {7'($urandom), w[8]} : {7'd0, w[8]};
            send_byte(w[7:0]);
            send_byte(hi);
        end
        // Offer a junk byte for the whole run; it must never be taken.
        rdy_seen = 1'b0;
        for (g = 0; g < 400; g++) begin
            @(negedge clk);
            if (cycles_valid) break;
            if (in_ready) rdy_seen = 1'b1;
            in_valid = 1'b1;
            in_data  = 8'hA5;
        end
        in_valid = 1'b0;
        check("fin_reached", 32'(g < 400), 1);
        check("no_ready_while_running", 32'(rdy_seen), 0);
    endtask

    initial begin : stim
        int ws[$];
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_outputs_zero",
                  32'(|{in_ready, im_we, im_addr, im_wdata, Start, busy, cycles, cycles_valid, err}), 0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(in_ready), 1);

        ws = '{32'h111, 32'h022, 32'h133};
        run_prog(ws, 4'h0, 9, 1'b0);

        ws = {};
        run_prog(ws, 4'hF, 5, 1'b0);

        ws = '{32'h1FF};
        run_prog(ws, 4'h0, 40, 1'b1);

        for (int k = 0; k < 6; k++) begin
            ws = {};
            n  = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) ws.push_back($urandom_range(0, 511));
            run_prog(ws, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                     $urandom_range(0, 25), 1'b1);
        end

        // Abort between the low and high bytes of word 1.
        begin
            wr_t e;
            e.addr = 0; e.data = 32'h0AB;
            wr_q.push_back(e);
            send_byte(8'h02);
            send_byte(8'h00);
            send_byte(8'hAB);
            send_byte(8'h00);
            send_byte(8'h5C);
            @(negedge clk);
            in_valid = 1'b0;
            rst_n    = 1'b0;
            #1;
            check("abort_start", 32'(Start), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_ready", 32'(in_ready), 0);
            check("abort_we", 32'(im_we), 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("abort_idle_ready", 32'(in_ready), 1);
            repeat (3) @(negedge clk);
            check("abort_no_pending_write", wr_q.size(), 0);
        end

        ws = '{32'h0F0, 32'h10F};
        run_prog(ws, 4'h0, 3, 1'b1);

        repeat (5) @(negedge clk);
        check("wr_q_drained", wr_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired=1 required=0");
        $fatal(1, "watchdog");
    end

endmodule
